residual_relu_unit: RTL and testbench

RESIDUAL_RELU_UNIT -- requirements
Module: residual_relu_unit

---
 rtl/residual_relu_unit.sv | 127 ++++++++++++
 tb/tb_residual_relu_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/residual_relu_unit.sv
// residual_relu_unit
//   Adds one row of 4-bit unsigned residuals to a row of 16-bit signed
//   partial sums read from the output SRAM. It applies ReLU with saturation
//   to 32767 and writes the row back. A sequence walks rows 0..ROWS-1.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse that begins a sequence; ignored unless idle
//   busy       high while a sequence is in progress
//   done       one-cycle pulse in the cycle after the last write-back
//   op_addr    output-SRAM row address
//   op_cen     output-SRAM chip enable, active-low
//   op_wen     output-SRAM write enable, active-low
//   op_q       output-SRAM read data, valid one cycle after a read
//   op_d       output-SRAM write data
//   res_data   residuals, lane j at [RES_BW*j +: RES_BW]
//   res_valid  res_data is valid
//   res_ready  the block consumes res_data this cycle
//   dbg_state  current FSM state, for observation only
//
// Residual handshake: a residual row is consumed on a rising edge where
// res_valid and res_ready are both high. res_ready is high only in ADD and
// does not depend on res_valid. While res_valid is low in ADD the block waits
// indefinitely, and data offered in any other state is left untouched.
module residual_relu_unit #(
    parameter int ROWS   = 16,
    parameter int LANES  = 8,
    parameter int RES_BW = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                op_addr,
    output logic                      op_cen,
    output logic                      op_wen,
    input  logic [LANES*16-1:0]       op_q,
    output logic [LANES*16-1:0]       op_d,
    input  logic [LANES*RES_BW-1:0]   res_data,
    input  logic                      res_valid,
    output logic                      res_ready,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        ADD   = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            row;
    logic [LANES*16-1:0]   psum;
    logic [LANES*16-1:0]   result;
    logic [LANES*16-1:0]   lane_res;
    logic [16:0]           lane_sum [LANES];

    // 17 bits hold any sign-extended psum plus a zero-extended residual
    // without overflow. Bit 16 set means a negative sum. Otherwise bit 15 set
    // means the sum exceeds 32767.
    always_comb begin
        lane_res = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum[j] = {psum[16*j+15], psum[16*j +: 16]}
                        + {{(17-RES_BW){1'b0}}, res_data[RES_BW*j +: RES_BW]};
            if (lane_sum[j][16])
                lane_res[16*j +: 16] = 16'h0000;
            else if (lane_sum[j][15])
                lane_res[16*j +: 16] = 16'h7FFF;
            else
                lane_res[16*j +: 16] = lane_sum[j][15:0];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = CAPT;
            CAPT:    state_nxt = ADD;
            ADD:     if (res_valid) state_nxt = WRITE;
            WRITE:   state_nxt = (row == LAST_ROW) ? FIN : READ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            row    <= '0;
            psum   <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start)
                row <= '0;
            // The last row keeps its index so the counter never wraps.
            else if (state == WRITE && row != LAST_ROW)
                row <= row + 4'd1;
            if (state == CAPT)
                psum <= op_q;
            if (state == ADD && res_valid)
                result <= lane_res;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        res_ready = (state == ADD);
        op_cen    = !(state == READ || state == WRITE);
        op_wen    = (state != WRITE);
        op_addr   = row;
        op_d      = result;
        dbg_state = state;
    end

endmodule

// File: tb/tb_residual_relu_unit.sv
module tb_residual_relu_unit;

  localparam int ROWS = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic         busy;
  logic         done;
  logic [3:0]   op_addr;
  logic         op_cen;
  logic         op_wen;
  logic [127:0] op_q;
  logic [127:0] op_d;
  logic [31:0]  res_data;
  logic         res_valid;
  logic         res_ready;
  logic [2:0]   dbg_state;

  residual_relu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .op_addr   (op_addr),
    .op_cen    (op_cen),
    .op_wen    (op_wen),
    .op_q      (op_q),
    .op_d      (op_d),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- state ----------------
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int res_idx = 0;
  int res_mode = 0;
  int stall_left = 0;
  int stall_seen = 0;
  int stall_row = 5;
  logic [127:0] mem [ROWS];
  logic [31:0]  res_vals [ROWS];
  logic [127:0] row0_data;
  logic [131:0] exp_q [$];

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: each lane is psum + residual in plain integer arithmetic,
  // then clamped to [0, 32767].
  function automatic logic [127:0] model_row(input logic [127:0] p, input logic [31:0] r);
    logic [127:0] o;
    int s;
    logic [15:0] pl;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      pl = p[16*j +: 16];
      s = int'($signed(pl)) + int'(r[4*j +: 4]);
      if (s < 0) s = 0;
      else if (s > 32767) s = 32767;
      o[16*j +: 16] = 16'(s);
    end
    return o;
  endfunction

  // ---------------- SRAM model ----------------
  always @(posedge clk)
    if (!op_cen && op_wen) op_q <= mem[op_addr];

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        done_cnt++;
        check("done_implies_busy", 132'(busy), 132'(1));
      end
      if (!op_cen && !op_wen) begin
        wr_cnt++;
        if (op_addr == 4'd0) row0_data = op_d;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d data %h with no write expected", op_addr, op_d);
        end else begin
          check("write_addr_data", {op_addr, op_d}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- residual driver ----------------
  initial begin
    logic hs;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      hs = reset && res_valid && res_ready;
      @(posedge clk);
      #1;
      if (hs) res_idx++;
      if (stall_left > 0 && res_idx == stall_row && res_ready) begin
        res_valid = 1'b0;
        stall_left--;
        stall_seen++;
        check("stall_no_sram_access", 132'(op_cen), 132'(1));
        check("stall_holds_add", 132'(res_ready), 132'(1));
      end else if (res_mode == 0) begin
        res_valid = 1'b1;
      end else begin
        res_valid = ($urandom_range(0, 3) != 0);
      end
      if (res_valid && res_idx < ROWS) res_data = res_vals[res_idx];
      else res_data = $urandom();
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic load(input bit directed);
    logic [15:0] lane;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < 8; j++) begin
        case ($urandom_range(0, 3))
          0: lane = 16'h7FF0 + 16'($urandom_range(0, 15));
          1: lane = 16'hFFF0 + 16'($urandom_range(0, 15));
          default: lane = 16'($urandom());
        endcase
        mem[r][16*j +: 16] = lane;
      end
      res_vals[r] = $urandom();
    end
    if (directed) begin
      mem[0][15:0]        = 16'hFFF6;
      res_vals[0][3:0]    = 4'h3;
      mem[0][63:48]       = 16'h0064;
      res_vals[0][15:12]  = 4'hF;
      mem[0][127:112]     = 16'h7FFE;
      res_vals[0][31:28]  = 4'h5;
    end
    for (int r = 0; r < ROWS; r++)
      exp_q.push_back({4'(r), model_row(mem[r], res_vals[r])});
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_seq(input int mode, input bit do_stall, input bit mid_start,
                         input bit fin_start, input bit directed, input int want_lat);
    int lat;
    int d0;
    bit mid_done;
    load(directed);
    res_mode   = mode;
    res_idx    = 0;
    stall_left = do_stall ? 10 : 0;
    stall_seen = 0;
    d0         = done_cnt;
    mid_done   = 1'b0;
    pulse_start();
    lat = 1;
    while (!done && lat < 3000) begin
      start = 1'b0;
      if (mid_start && !mid_done && op_addr == 4'd7) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL done_timeout: no done after %0d cycles", lat);
    end
    if (want_lat > 0) check("done_latency", 132'(lat), 132'(want_lat));
    start = fin_start;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_done", 132'(busy), 132'(0));
    check("done_one_cycle", 132'(done), 132'(0));
    repeat (3) @(posedge clk);
    #1;
    check("stays_idle", 132'(busy), 132'(0));
    check("all_rows_written", 132'(exp_q.size()), 132'(0));
    check("one_done_pulse", 132'(done_cnt - d0), 132'(1));
    check("residuals_consumed", 132'(res_idx), 132'(ROWS));
    if (do_stall) check("stall_cycles", 132'(stall_seen), 132'(10));
    if (directed) begin
      check("lane0_relu_clamp", 132'(row0_data[15:0]), 132'(16'h0000));
      check("lane3_add", 132'(row0_data[63:48]), 132'(16'h0073));
      check("lane7_saturate", 132'(row0_data[127:112]), 132'(16'h7FFF));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    int n;
    reset = 1'b0;
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    // Pin the reference model with hand-computed values.
    check("model_clamp", 132'(model_row(128'h0000_0000_0000_0000_0000_0000_0000_FFF6, 32'h3)), 132'(0));
    check("model_add", 132'(model_row(128'h0000_0000_0000_0000_0064_0000_0000_0000, 32'h0000_F000)),
          132'(128'h0000_0000_0000_0000_0073_0000_0000_0000));
    check("model_sat", 132'(model_row(128'h7FFE_0000_0000_0000_0000_0000_0000_0000, 32'h5000_0000)),
          132'(128'h7FFF_0000_0000_0000_0000_0000_0000_0000));
    #1;
    check("rst_busy", 132'(busy), 132'(0));
    check("rst_done", 132'(done), 132'(0));
    check("rst_res_ready", 132'(res_ready), 132'(0));
    check("rst_op_cen", 132'(op_cen), 132'(1));
    check("rst_op_wen", 132'(op_wen), 132'(1));
    check("rst_op_addr", 132'(op_addr), 132'(0));
    check("rst_op_d", 132'(op_d), 132'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_start_on_reset_release", 132'(busy), 132'(0));

    // Valid tied high, directed lanes on row 0, start during FIN.
    run_seq(0, 1'b0, 1'b0, 1'b1, 1'b1, 65);
    // Random valid, 10-cycle stall at row 5, start pulsed during row 7.
    run_seq(1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Abort during the write-back of row 9.
    load(1'b0);
    res_mode   = 0;
    res_idx    = 0;
    stall_left = 0;
    w0 = wr_cnt;
    pulse_start();
    n = 0;
    while (!(!op_wen && op_addr == 4'd9) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_row9_write", 132'(!op_wen && op_addr == 4'd9), 132'(1));
    reset = 1'b0;
    #1;
    check("abort_op_cen", 132'(op_cen), 132'(1));
    check("abort_op_wen", 132'(op_wen), 132'(1));
    check("abort_busy", 132'(busy), 132'(0));
    check("abort_op_addr", 132'(op_addr), 132'(0));
    check("abort_op_d", 132'(op_d), 132'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_writes_before_reset", 132'(wr_cnt - w0), 132'(9));
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_abort", 132'(busy), 132'(0));

    // Fresh sequences restart from row 0.
    run_seq(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_seq(0, 1'b0, 1'b0, 1'b0, 1'b0, 65);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
